target_list_reader: RTL and testbench
=====================================

# target_list_reader

Frame-end readout controller for the 16-entry moving-target list. At the end of each frame it snapshots the detector's target array and filters entries by minimum box size. It then streams the qualifying boxes one at a time over a valid/ready handshake to downstream consumers: the overlay drawer and the UART reporter. It sequences the list so that no consumer reads the detector's live, mid-frame registers.

## Interface
- N_TGT, 16: number of list entries; index width is 4 bits.
- clk  in  1  pixel clock, same domain as the detector.
- rst_n  in  1  reset; asynchronous, active-low.
- frame_vsync  in  1  frame sync, high during vertical blanking. The detector clears its list on the falling edge.
- target_pos_in  in  41 x N_TGT  live list. Each entry is {flag[40], ymax[39:30], xmax[29:20], ymin[19:10], xmin[9:0]}.
- enable  in  1  arms the readout. Sampled only in IDLE.
- min_w  in  10  minimum box width in pixels. A value of 0 disables the width check.
- min_h  in  10  minimum box height in pixels. A value of 0 disables the height check.
- box_valid  out  1  output beat valid.
- box_ready  in  1  downstream accepts the beat.
- box_data  out  40  {ymax, xmax, ymin, xmin} of the current entry.
- box_index  out  4  list index of the current entry.
- box_last  out  1  current beat is the last qualifying box of the frame.
- frame_box_cnt  out  5  number of boxes emitted in the last completed readout (0..16).
- done  out  1  one-cycle pulse when a readout completes.
- busy  out  1  high from snapshot until done.
- overrun  out  1  one-cycle pulse when a frame end arrives while busy.

## Operation
- frame_vsync is registered once, into vsync_r. rise = frame_vsync & ~vsync_r.
- States are IDLE, MASK, SCAN, EMIT, DONE.
- IDLE → MASK on rise && enable.
  - In that same cycle, all 16 entries are copied into shadow registers.
  - idx is cleared and the emitted-box count is cleared.
- MASK computes a 16-bit qualify mask from the shadow registers and goes to SCAN.
  - mask[i] = flag & (xmax ≥ xmin) & (ymax ≥ ymin) & (xmax−xmin+1 ≥ min_w) & (ymax−ymin+1 ≥ min_h).
  - All size arithmetic is 11-bit unsigned, so nothing wraps.
  - An entry with inverted bounds is rejected.
- SCAN handles one entry per cycle.
  - If mask[idx] = 1: load box_data, box_index = idx, box_last = ~|(mask >> (idx+1)); go to EMIT.
  - If mask[idx] = 0 and idx = 15: go to DONE.
  - If mask[idx] = 0 and idx < 15: idx++, stay in SCAN.
- EMIT holds box_valid = 1. box_data, box_index and box_last stay stable until box_ready.
  - On box_valid & box_ready: the emitted count increments.
  - Then, if idx = 15 or box_last = 1: go to DONE.
  - Otherwise: idx++ and go to SCAN.
- DONE lasts one cycle, then returns to IDLE.
  - done = 1.
  - frame_box_cnt is set to the emitted count.
- busy = 1 in every state except IDLE.
- A rise while busy pulses overrun.
  - The shadow registers are not touched and the current readout finishes on the old snapshot.
  - That frame is dropped.
- enable is ignored outside IDLE. Deasserting it mid-readout does not abort the readout.
- The shadow registers make the module immune to the detector clearing its list on the vsync falling edge.
- Reset values: state IDLE, idx 0, shadow registers 0, mask 0. Every output is 0: box_valid, box_data, box_index, box_last, frame_box_cnt, done, busy, overrun.
- Reset mid-readout drops the beat in flight. No partial done is issued.

## Timing
- Let T be the cycle in which rise is seen in IDLE.
  - The snapshot is registered at the end of T.
  - MASK occupies T+1.
  - SCAN for idx 0 occupies T+2.
- The earliest box_valid is at T+3.
- Between accepted beats there is a minimum of one SCAN cycle, plus one cycle per skipped entry. Peak throughput is one box every 2 cycles.
- Worst-case readout with box_ready held at 1 is 2 + 16 + 16 + 1 = 35 cycles after T. This is far below the vertical blanking length.
- With an empty mask: SCAN runs for 16 cycles, DONE is at T+18, done pulses, frame_box_cnt = 0, and box_valid is never asserted.
- frame_box_cnt updates in the DONE cycle, on the same edge that raises done. It holds until the next DONE.
- box_valid must never deassert without a handshake. box_data must not change while box_valid & ~box_ready.

## Test plan
- Entries 0, 5 and 15 valid, each 10×10; min_w = min_h = 4; box_ready = 1 → three beats with indices 0, 5, 15; box_last only on 15; done pulses; frame_box_cnt = 3.
- Size boundary: min_w = 4; entry 2 has xmin = 10, xmax = 12 (width 3); entry 3 has xmin = 10, xmax = 13 (width 4); both have flag = 1 and height ≥ 4 → only index 3 is emitted, with box_last = 1 and frame_box_cnt = 1.
- Backpressure: two qualifying entries; box_ready low for 20 cycles on the first beat → box_valid, box_data and box_index stay stable for all 20 cycles; both beats are delivered in order; frame_box_cnt = 2.
- Empty list (all flags 0) or enable = 0 at rise: if enable = 1 → no box_valid, done pulses at T+18, frame_box_cnt = 0. If enable = 0 → the block stays in IDLE, busy = 0, and no done.
- Overrun: box_ready held low; a second frame_vsync rise arrives while in EMIT, and the live list is changed → overrun pulses for 1 cycle; after box_ready is released the old snapshot's boxes are emitted unchanged.
- Reset mid-EMIT: rst_n is pulsed low while box_valid = 1 → all outputs are 0 immediately (asynchronous); after release the block sits in IDLE until the next rise with enable = 1.

Source files
------------

// File: rtl/target_list_reader_if.sv
// target_list_reader_if: valid/ready stream of qualifying target boxes
interface target_list_reader_if;
    logic        box_valid;
    logic        box_ready;
    logic [39:0] box_data;
    logic [3:0]  box_index;
    logic        box_last;
    modport master (output box_valid, box_data, box_index, box_last, input box_ready);
    modport slave  (input box_valid, box_data, box_index, box_last, output box_ready);
endinterface

// File: rtl/target_list_reader.sv
// target_list_reader: frame-end snapshot, size filter and streaming readout of the target list
module target_list_reader #(
    parameter int N_TGT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_vsync_i,
    input  logic [41*N_TGT-1:0]   target_pos_in_i,
    input  logic                  enable_i,
    input  logic [9:0]            min_w_i,
    input  logic [9:0]            min_h_i,
    target_list_reader_if.master  box_o,
    output logic [4:0]            frame_box_cnt_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  overrun_o
);
    typedef enum logic [2:0] {IDLE, MASK, SCAN, EMIT, DONE} state_t;
    state_t            state_q, state_d;
    logic              vsync_q, rise, snap, load, fire, end_idx, last_d;
    logic [40:0]       shadow_q [N_TGT];
    logic [N_TGT-1:0]  mask_q, mask_d;
    logic [3:0]        idx_q, idx_d, index_q;
    logic [4:0]        cnt_q, cnt_d, frame_cnt_q;
    logic [39:0]       data_q;
    logic              last_q, overrun_q;

    // Widths are taken in 11 bits so a full-frame box (1024 px) still compares correctly
    function automatic logic qualify(input logic [40:0] e, input logic [9:0] mw, input logic [9:0] mh);
        logic [10:0] w, h;
        w = {1'b0, e[29:20]} - {1'b0, e[9:0]} + 11'd1;
        h = {1'b0, e[39:30]} - {1'b0, e[19:10]} + 11'd1;
        return e[40] && (e[29:20] >= e[9:0]) && (e[39:30] >= e[19:10]) &&
               (w >= {1'b0, mw}) && (h >= {1'b0, mh});
    endfunction

    assign rise    = frame_vsync_i & ~vsync_q;
    assign snap    = (state_q == IDLE) && rise && enable_i;
    assign load    = (state_q == SCAN) && mask_q[idx_q];
    assign fire    = (state_q == EMIT) && box_o.box_ready;
    assign end_idx = idx_q == 4'(N_TGT - 1);
    assign last_d  = ~|(mask_q >> ({1'b0, idx_q} + 5'd1));

    // Qualify mask over the frozen snapshot
    always_comb begin
        mask_d = '0;
        for (int i = 0; i < N_TGT; i++) mask_d[i] = qualify(shadow_q[i], min_w_i, min_h_i);
    end

    // Next-state: walk the mask one entry per cycle, park in EMIT until the beat is taken
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (rise && enable_i) begin
                state_d = MASK;
                idx_d   = '0;
                cnt_d   = '0;
            end
            MASK: state_d = SCAN;
            SCAN: begin
                if (mask_q[idx_q]) state_d = EMIT;
                else if (end_idx) state_d = DONE;
                else idx_d = idx_q + 4'd1;
            end
            EMIT: if (box_o.box_ready) begin
                cnt_d = cnt_q + 5'd1;
                if (end_idx || last_q) state_d = DONE;
                else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = SCAN;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, counters, vsync edge detector and overrun pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            vsync_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= (state_d == DONE) ? cnt_d : frame_cnt_q;
            vsync_q     <= frame_vsync_i;
            overrun_q   <= rise && (state_q != IDLE);
        end
    end

    // Snapshot of the live list, taken only when a readout is armed from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TGT; i++) shadow_q[i] <= '0;
        end else if (snap) begin
            for (int i = 0; i < N_TGT; i++) shadow_q[i] <= target_pos_in_i[i*41 +: 41];
        end
    end

    // Mask is latched once per readout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else if (state_q == MASK) mask_q <= mask_d;
    end

    // Beat payload, loaded when SCAN finds a qualifying entry and held through EMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            data_q  <= shadow_q[idx_q][39:0];
            index_q <= idx_q;
            last_q  <= last_d;
        end
    end

    assign box_o.box_valid = state_q == EMIT;
    assign box_o.box_data  = data_q;
    assign box_o.box_index = index_q;
    assign box_o.box_last  = last_q;
    assign frame_box_cnt_o = frame_cnt_q;
    assign done_o          = state_q == DONE;
    assign busy_o          = state_q != IDLE;
    assign overrun_o       = overrun_q;
    logic unused_fire;
    assign unused_fire = fire;
endmodule

// File: tb/tb_target_list_reader.sv
// tb_target_list_reader: randomized and directed checks of the target list readout
module tb_target_list_reader;
    logic clk = 0, rst_n = 0, frame_vsync = 0, enable = 0;
    logic [9:0] min_w = 0, min_h = 0;
    logic [40:0] live [16];
    logic [40:0] snap [16];
    logic [41*16-1:0] tpos;
    logic [4:0] frame_box_cnt;
    logic done, busy, overrun;
    int n_checks = 0, n_fail = 0, cyc = 0;
    int done_cnt, done_cyc, ovr_cnt, busy_cnt, stab_err, first_valid;
    logic [3:0]  got_idx[$];
    logic [39:0] got_data[$];
    logic        got_last[$];
    logic [3:0]  exp_idx[$];
    logic [39:0] exp_data[$];

    target_list_reader_if bif ();
    target_list_reader dut (.clk(clk), .rst_n(rst_n), .frame_vsync_i(frame_vsync), .target_pos_in_i(tpos),
        .enable_i(enable), .min_w_i(min_w), .min_h_i(min_h), .box_o(bif),
        .frame_box_cnt_o(frame_box_cnt), .done_o(done), .busy_o(busy), .overrun_o(overrun));

    always #5 clk = ~clk;
    always_comb for (int i = 0; i < 16; i++) tpos[i*41 +: 41] = live[i];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observer: records accepted beats, pulses and handshake stability
    initial begin
        logic pv, pr;
        logic [44:0] pd;
        pv = 0; pr = 0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) pv = 0;
            else begin
                if (pv && !pr && (!bif.box_valid || {bif.box_data, bif.box_index, bif.box_last} !== pd)) stab_err++;
                if (bif.box_valid && first_valid < 0) first_valid = cyc;
                if (bif.box_valid && bif.box_ready) begin
                    got_idx.push_back(bif.box_index);
                    got_data.push_back(bif.box_data);
                    got_last.push_back(bif.box_last);
                end
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (overrun) ovr_cnt++;
                if (busy) busy_cnt++;
                pv = bif.box_valid; pr = bif.box_ready;
                pd = {bif.box_data, bif.box_index, bif.box_last};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [40:0] make_e(int f, int x0, int y0, int x1, int y1);
        return {1'(f), 10'(y1), 10'(x1), 10'(y0), 10'(x0)};
    endfunction

    task automatic clear_mon();
        done_cnt = 0; ovr_cnt = 0; busy_cnt = 0; stab_err = 0; first_valid = -1; done_cyc = -1;
        got_idx.delete(); got_data.delete(); got_last.delete();
    endtask

    task automatic clear_live();
        for (int i = 0; i < 16; i++) live[i] = '0;
    endtask

    task automatic rand_list();
        for (int i = 0; i < 16; i++) begin
            int x0, y0, x1, y1;
            x0 = $urandom_range(0, 1000); y0 = $urandom_range(0, 1000);
            x1 = x0 + $urandom_range(0, 12); y1 = y0 + $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) begin int t; t = x0; x0 = x1; x1 = t; end
            if ($urandom_range(0, 7) == 0) begin int t; t = y0; y0 = y1; y1 = t; end
            live[i] = make_e(($urandom_range(0, 3) != 0) ? 1 : 0, x0, y0, x1, y1);
        end
    endtask

    task automatic start_frame(output int t);
        @(posedge clk); #1;
        frame_vsync = 1;
        t = cyc;
        snap = live;
        repeat (3) @(posedge clk);
        #1 frame_vsync = 0;
    endtask

    // Reference: a box qualifies when flagged, not inverted, and at least min_w x min_h
    task automatic build_model();
        exp_idx.delete(); exp_data.delete();
        for (int i = 0; i < 16; i++) begin
            int x0, y0, x1, y1;
            x0 = int'(snap[i][9:0]); y0 = int'(snap[i][19:10]);
            x1 = int'(snap[i][29:20]); y1 = int'(snap[i][39:30]);
            if (snap[i][40] && x1 >= x0 && y1 >= y0 && x1 - x0 + 1 >= int'(min_w) && y1 - y0 + 1 >= int'(min_h)) begin
                exp_idx.push_back(4'(i));
                exp_data.push_back(snap[i][39:0]);
            end
        end
    endtask

    function automatic int exp_done_cyc(int t);
        return t + 2 + (exp_idx.size() == 0 ? 16 : int'(exp_idx[exp_idx.size()-1]) + 1) + exp_idx.size();
    endfunction

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done_cnt != 0) begin ok = 1; break; end
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (first_valid >= 0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bif.box_valid, bif.box_data, bif.box_index, bif.box_last, frame_box_cnt, done, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {bif.box_valid, bif.box_data, bif.box_index, bif.box_last, frame_box_cnt, done, busy, overrun});
        end
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_three();
        int t; bit ok;
        clear_live();
        live[0]  = make_e(1, 100, 50, 109, 59);
        live[5]  = make_e(1, 300, 200, 309, 209);
        live[15] = make_e(1, 1014, 900, 1023, 909);
        min_w = 4; min_h = 4; enable = 1; bif.box_ready = 1;
        clear_mon();
        start_frame(t);
        clear_live();
        build_model();
        wait_done(80, ok);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL three_timeout: got no done want done"); end
        n_checks++;
        if (got_idx.size() != exp_idx.size()) begin
            n_fail++; $display("FAIL three_count: got %0d beats want %0d", got_idx.size(), exp_idx.size());
        end else foreach (exp_idx[i]) begin
            n_checks++;
            if ({got_idx[i], got_data[i], got_last[i]} !== {exp_idx[i], exp_data[i], 1'(i == exp_idx.size() - 1)}) begin
                n_fail++; $display("FAIL three_beat%0d: got %h want %h", i, {got_idx[i], got_data[i], got_last[i]}, {exp_idx[i], exp_data[i], 1'(i == exp_idx.size() - 1)});
            end
        end
        n_checks++;
        if (first_valid != t + 3) begin n_fail++; $display("FAIL three_first_valid: got %0d want %0d", first_valid, t + 3); end
        n_checks++;
        if (done_cyc != t + 21) begin n_fail++; $display("FAIL three_done_cyc: got %0d want %0d", done_cyc, t + 21); end
        n_checks++;
        if (frame_box_cnt !== 5'd3) begin n_fail++; $display("FAIL three_frame_cnt: got %0d want 3", frame_box_cnt); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL three_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_size_boundary();
        int t; bit ok;
        clear_live();
        live[2] = make_e(1, 10, 0, 12, 5);
        live[3] = make_e(1, 10, 0, 13, 5);
        min_w = 4; min_h = 4; enable = 1; bif.box_ready = 1;
        clear_mon();
        start_frame(t);
        build_model();
        wait_done(60, ok);
        #1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL size_timeout: got no done want done"); end
        n_checks++;
        if (got_idx.size() != 1) begin
            n_fail++; $display("FAIL size_count: got %0d beats want 1", got_idx.size());
        end else begin
            n_checks++;
            if ({got_idx[0], got_data[0], got_last[0]} !== {4'd3, live[3][39:0], 1'b1}) begin
                n_fail++; $display("FAIL size_beat: got %h want %h", {got_idx[0], got_data[0], got_last[0]}, {4'd3, live[3][39:0], 1'b1});
            end
        end
        n_checks++;
        if (frame_box_cnt !== 5'd1) begin n_fail++; $display("FAIL size_frame_cnt: got %0d want 1", frame_box_cnt); end
        n_checks++;
        if (done_cyc != t + 7) begin n_fail++; $display("FAIL size_done_cyc: got %0d want %0d", done_cyc, t + 7); end
    endtask

    task automatic test_backpressure();
        int t; bit ok; logic [43:0] held;
        clear_live();
        live[4] = make_e(1, 20, 30, 40, 50);
        live[9] = make_e(1, 600, 700, 601, 700);
        min_w = 0; min_h = 0; enable = 1; bif.box_ready = 0;
        clear_mon();
        start_frame(t);
        build_model();
        wait_valid(30, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_valid_timeout: got no valid want valid"); end
        held = {bif.box_data, bif.box_index};
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (!bif.box_valid || {bif.box_data, bif.box_index} !== held) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b %h want v=1 %h", k, bif.box_valid, {bif.box_data, bif.box_index}, held);
            end
        end
        bif.box_ready = 1;
        wait_done(60, ok);
        #1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no done want done"); end
        n_checks++;
        if (got_idx.size() != exp_idx.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d beats want %0d", got_idx.size(), exp_idx.size());
        end else foreach (exp_idx[i]) begin
            n_checks++;
            if ({got_idx[i], got_data[i], got_last[i]} !== {exp_idx[i], exp_data[i], 1'(i == exp_idx.size() - 1)}) begin
                n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, {got_idx[i], got_data[i], got_last[i]}, {exp_idx[i], exp_data[i], 1'(i == exp_idx.size() - 1)});
            end
        end
        n_checks++;
        if (frame_box_cnt !== 5'd2) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d want 2", frame_box_cnt); end
        n_checks++;
        if (stab_err != 0) begin n_fail++; $display("FAIL bp_stability: got %0d violations want 0", stab_err); end
    endtask

    task automatic test_empty();
        int t; bit ok;
        rand_list();
        for (int i = 0; i < 16; i++) live[i][40] = 1'b0;
        min_w = 0; min_h = 0; enable = 1; bif.box_ready = 1;
        clear_mon();
        start_frame(t);
        wait_done(60, ok);
        #1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL empty_timeout: got no done want done"); end
        n_checks++;
        if (done_cyc != t + 18) begin n_fail++; $display("FAIL empty_done_cyc: got %0d want %0d", done_cyc, t + 18); end
        n_checks++;
        if (first_valid != -1 || got_idx.size() != 0) begin n_fail++; $display("FAIL empty_valid: got first_valid %0d want -1", first_valid); end
        n_checks++;
        if (frame_box_cnt !== 5'd0) begin n_fail++; $display("FAIL empty_frame_cnt: got %0d want 0", frame_box_cnt); end
        rand_list();
        live[7] = make_e(1, 5, 5, 50, 50);
        enable = 0;
        clear_mon();
        start_frame(t);
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (busy_cnt != 0 || done_cnt != 0 || got_idx.size() != 0) begin
            n_fail++; $display("FAIL disabled_idle: got busy %0d done %0d beats %0d want 0 0 0", busy_cnt, done_cnt, got_idx.size());
        end
        enable = 1;
    endtask

    task automatic test_overrun();
        int t; bit ok;
        clear_live();
        live[1] = make_e(1, 100, 100, 120, 130);
        live[6] = make_e(1, 400, 10, 410, 20);
        min_w = 2; min_h = 2; enable = 1; bif.box_ready = 0;
        clear_mon();
        start_frame(t);
        build_model();
        wait_valid(30, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ovr_valid_timeout: got no valid want valid"); end
        rand_list();
        for (int i = 0; i < 16; i++) live[i][40] = 1'b1;
        @(posedge clk); #1 frame_vsync = 1;
        repeat (2) @(posedge clk);
        #1 frame_vsync = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ovr_cnt != 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d cycles want 1", ovr_cnt); end
        n_checks++;
        if (bif.box_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL ovr_still_emit: got v=%b busy=%b want 1 1", bif.box_valid, busy); end
        bif.box_ready = 1;
        wait_done(60, ok);
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (!ok || done_cnt != 1) begin n_fail++; $display("FAIL ovr_done: got %0d done pulses want 1", done_cnt); end
        n_checks++;
        if (got_idx.size() != exp_idx.size()) begin
            n_fail++; $display("FAIL ovr_count: got %0d beats want %0d", got_idx.size(), exp_idx.size());
        end else foreach (exp_idx[i]) begin
            n_checks++;
            if ({got_idx[i], got_data[i], got_last[i]} !== {exp_idx[i], exp_data[i], 1'(i == exp_idx.size() - 1)}) begin
                n_fail++; $display("FAIL ovr_beat%0d: got %h want %h", i, {got_idx[i], got_data[i], got_last[i]}, {exp_idx[i], exp_data[i], 1'(i == exp_idx.size() - 1)});
            end
        end
        n_checks++;
        if (frame_box_cnt !== 5'(exp_idx.size())) begin n_fail++; $display("FAIL ovr_frame_cnt: got %0d want %0d", frame_box_cnt, exp_idx.size()); end
    endtask

    task automatic test_reset_mid_emit();
        int t; bit ok;
        clear_live();
        live[3] = make_e(1, 1, 2, 30, 40);
        live[8] = make_e(1, 50, 60, 70, 80);
        min_w = 0; min_h = 0; enable = 1; bif.box_ready = 0;
        clear_mon();
        start_frame(t);
        wait_valid(30, ok);
        @(posedge clk); #2 rst_n = 0;
        #1;
        n_checks++;
        if ({bif.box_valid, bif.box_data, bif.box_index, bif.box_last, frame_box_cnt, done, busy, overrun} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", {bif.box_valid, bif.box_data, bif.box_index, bif.box_last, frame_box_cnt, done, busy, overrun});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        bif.box_ready = 1;
        clear_mon();
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (busy_cnt != 0 || done_cnt != 0 || got_idx.size() != 0) begin
            n_fail++; $display("FAIL rst_mid_idle: got busy %0d done %0d beats %0d want 0 0 0", busy_cnt, done_cnt, got_idx.size());
        end
        start_frame(t);
        build_model();
        wait_done(60, ok);
        #1;
        n_checks++;
        if (!ok || frame_box_cnt !== 5'(exp_idx.size())) begin
            n_fail++; $display("FAIL rst_mid_rearm: got done=%b cnt %0d want done=1 cnt %0d", ok, frame_box_cnt, exp_idx.size());
        end
    endtask

    task automatic test_random();
        int t; bit ok; bit rnd;
        for (int k = 0; k < 24; k++) begin
            rand_list();
            min_w = 10'($urandom_range(0, 9));
            min_h = 10'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) min_w = 0;
            rnd = k[0];
            enable = 1; bif.box_ready = 1;
            clear_mon();
            start_frame(t);
            build_model();
            ok = 0;
            for (int c = 0; c < 300; c++) begin
                @(posedge clk); #1;
                if (done_cnt != 0) begin ok = 1; break; end
                if (rnd) bif.box_ready = 1'($urandom_range(0, 1));
            end
            bif.box_ready = 1;
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: got no done want done", k); end
            n_checks++;
            if (got_idx.size() != exp_idx.size()) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d beats want %0d", k, got_idx.size(), exp_idx.size());
            end else foreach (exp_idx[i]) begin
                n_checks++;
                if ({got_idx[i], got_data[i], got_last[i]} !== {exp_idx[i], exp_data[i], 1'(i == exp_idx.size() - 1)}) begin
                    n_fail++; $display("FAIL rand%0d_beat%0d: got %h want %h", k, i, {got_idx[i], got_data[i], got_last[i]}, {exp_idx[i], exp_data[i], 1'(i == exp_idx.size() - 1)});
                end
            end
            n_checks++;
            if (frame_box_cnt !== 5'(exp_idx.size())) begin n_fail++; $display("FAIL rand%0d_frame_cnt: got %0d want %0d", k, frame_box_cnt, exp_idx.size()); end
            n_checks++;
            if (stab_err != 0) begin n_fail++; $display("FAIL rand%0d_stability: got %0d violations want 0", k, stab_err); end
            if (!rnd) begin
                n_checks++;
                if (done_cyc != exp_done_cyc(t)) begin n_fail++; $display("FAIL rand%0d_done_cyc: got %0d want %0d", k, done_cyc, exp_done_cyc(t)); end
            end
        end
    endtask

    initial begin
        clear_live();
        for (int i = 0; i < 16; i++) snap[i] = '0;
        bif.box_ready = 0;
        clear_mon();
        test_reset();
        test_three();
        test_size_boundary();
        test_backpressure();
        test_empty();
        test_overrun();
        test_reset_mid_emit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
